// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised 2-read/1-write register file with a per-register
// busy scoreboard. Decode uses the busy bits for RAW-hazard stall decisions.
// Register 0 is hardwired to zero and is never marked busy.
// Build option: define RF_BYPASS_EN to forward same-cycle write-back data (and the
// resulting busy bit) to the read ports; otherwise reads return pre-edge state.
module regfile_scoreboard #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_addr,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wr_hit;
    logic              alloc_hit;

    // Writes and allocations to register 0 are no-ops.
    assign wr_hit    = wr_en && (wr_addr != '0);
    assign alloc_hit = alloc_en && (alloc_addr != '0);

    // Next-state scoreboard: write-back clears, issue sets; a same-cycle issue wins.
    always_comb begin
        // NOTE: default assigned first so every path drives busy_nxt; a missing default infers a latch.
        busy_nxt = busy;
        if (wr_hit) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (alloc_hit) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
    end

    // Population count of the next-state busy vector.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
        end
    end

    // State update: register array, scoreboard and registered busy count; rst dominates.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is reset (flops, not a RAM macro) because every register must read 0 after reset.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            // NOTE: non-blocking so every update in this block sees pre-edge values.
            if (wr_hit) begin
                regs[wr_addr] <= wr_data;
            end
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Read port 1: combinational from state, optional write-back forwarding, r0 forced to zero.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_busy1 = busy[rd_addr1];
`ifdef RF_BYPASS_EN
        if (wr_hit && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            rd_busy1 = alloc_hit && (alloc_addr == rd_addr1);
        end
`else
        // Same-cycle reads of the register being written see the old data and busy bit.
`endif
        if (rd_addr1 == '0) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end
    end

    // Read port 2: same behaviour as read port 1.
    always_comb begin
        rd_data2 = regs[rd_addr2];
        rd_busy2 = busy[rd_addr2];
`ifdef RF_BYPASS_EN
        if (wr_hit && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            rd_busy2 = alloc_hit && (alloc_addr == rd_addr2);
        end
`else
        // Same-cycle reads of the register being written see the old data and busy bit.
`endif
        if (rd_addr2 == '0) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed bench for regfile_scoreboard. Expected values are
// pushed into a scoreboard queue as stimulus is driven and popped when outputs are sampled.
module tb_regfile_scoreboard;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] rd_addr1, rd_addr2;
    logic [DATA_W-1:0] rd_data1, rd_data2;
    logic              rd_busy1, rd_busy2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              alloc_en;
    logic [ADDR_W-1:0] alloc_addr;
    logic [ADDR_W:0]   busy_cnt;

    regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_busy1  (rd_busy1),
        .rd_busy2  (rd_busy2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {S_DATA1, S_DATA2, S_BUSY1, S_BUSY2, S_CNT} sel_t;

    // Scoreboard: parallel queues of selector, tag and expected value.
    sel_t        sb_sel[$];
    string       sb_tag[$];
    logic [31:0] sb_exp[$];

    int errors = 0;
    int checks = 0;

    // Reference state of the register file.
    logic [DATA_W-1:0] m_regs [NREGS];
    logic [NREGS-1:0]  m_busy;

    function automatic logic [31:0] observe(sel_t s);
        case (s)
            S_DATA1: return 32'(rd_data1);
            S_DATA2: return 32'(rd_data2);
            S_BUSY1: return 32'(rd_busy1);
            S_BUSY2: return 32'(rd_busy2);
            default: return 32'(busy_cnt);
        endcase
    endfunction

    task automatic push(sel_t s, string tag, logic [31:0] v);
        sb_sel.push_back(s);
        sb_tag.push_back(tag);
        sb_exp.push_back(v);
    endtask

    // Pop every pending expectation and compare against the live outputs.
    task automatic check();
        sel_t        s;
        string       tag;
        logic [31:0] e;
        logic [31:0] obs;
        while (sb_sel.size() > 0) begin
            s   = sb_sel.pop_front();
            tag = sb_tag.pop_front();
            e   = sb_exp.pop_front();
            obs = observe(s);
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_data(logic [ADDR_W-1:0] a);
        if (a == '0) return '0;
`ifdef RF_BYPASS_EN
        if (wr_en === 1'b1 && wr_addr === a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(logic [ADDR_W-1:0] a);
        if (a == '0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (wr_en === 1'b1 && wr_addr === a) return (alloc_en === 1'b1 && alloc_addr === a);
`endif
        return m_busy[a];
    endfunction

    // Drive both read addresses, push model expectations, then sample away from the edge.
    task automatic read_check(logic [ADDR_W-1:0] a1, logic [ADDR_W-1:0] a2, string tag);
        rd_addr1 = a1;
        rd_addr2 = a2;
        push(S_DATA1, {tag, "_data1"}, 32'(exp_data(a1)));
        push(S_DATA2, {tag, "_data2"}, 32'(exp_data(a2)));
        push(S_BUSY1, {tag, "_busy1"}, 32'(exp_busy(a1)));
        push(S_BUSY2, {tag, "_busy2"}, 32'(exp_busy(a2)));
        push(S_CNT,   {tag, "_cnt"},   32'($countones(m_busy)));
        #1;
        check();
    endtask

    // Apply the current inputs to the model, then clock the DUT.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            if (wr_en === 1'b1 && wr_addr != '0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (alloc_en === 1'b1 && alloc_addr != '0) m_busy[alloc_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en      = 1'b0;
        alloc_en   = 1'b0;
        wr_addr    = 'x;
        wr_data    = 'x;
        alloc_addr = 'x;
    endtask

    task automatic do_write(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic do_alloc(logic [ADDR_W-1:0] a);
        alloc_en   = 1'b1;
        alloc_addr = a;
    endtask

    // Watchdog: the sequence below is fixed-length; this only guards against a stall.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        rd_addr1 = '0;
        rd_addr2 = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // 1. Reset state on every address, constant expectations.
        for (int a = 0; a < NREGS; a++) begin
            rd_addr1 = 4'(a);
            rd_addr2 = 4'(NREGS - 1 - a);
            push(S_DATA1, "t1_data1", 32'h0);
            push(S_DATA2, "t1_data2", 32'h0);
            push(S_BUSY1, "t1_busy1", 32'h0);
            push(S_BUSY2, "t1_busy2", 32'h0);
            push(S_CNT,   "t1_cnt",   32'h0);
            #1;
            check();
        end

        // Fill r1..r15 with distinct patterns; read the written and previous registers.
        for (int i = 1; i < NREGS; i++) begin
            do_write(4'(i), 16'(i * 'h1111) ^ 16'h00F0);
            read_check(4'(i), 4'(i - 1), "fill");
            tick();
        end
        idle();
        for (int a = 0; a < NREGS; a++) read_check(4'(a), 4'(NREGS - 1 - a), "sweep");

        // 2. Write BEEF to r5, then write to r0.
        do_write(4'd5, 16'hBEEF);
        tick();
        idle();
        rd_addr1 = 4'd5;
        push(S_DATA1, "t2_r5", 32'hBEEF);
        #1;
        check();
        do_write(4'd0, 16'h1234);
        tick();
        idle();
        rd_addr1 = 4'd0;
        rd_addr2 = 4'd0;
        push(S_DATA1, "t2_r0_p1", 32'h0);
        push(S_DATA2, "t2_r0_p2", 32'h0);
        push(S_BUSY1, "t2_r0_busy", 32'h0);
        #1;
        check();

        // 3. Alloc r3 then r7, then write r3.
        do_alloc(4'd3);
        tick();
        idle();
        do_alloc(4'd7);
        tick();
        idle();
        rd_addr1 = 4'd3;
        rd_addr2 = 4'd7;
        push(S_BUSY1, "t3_busy3", 32'h1);
        push(S_BUSY2, "t3_busy7", 32'h1);
        push(S_CNT,   "t3_cnt2",  32'h2);
        #1;
        check();
        do_write(4'd3, 16'h3333);
        tick();
        idle();
        push(S_BUSY1, "t3_busy3_clr", 32'h0);
        push(S_BUSY2, "t3_busy7_hold", 32'h1);
        push(S_CNT,   "t3_cnt1", 32'h1);
        push(S_DATA1, "t3_r3", 32'h3333);
        #1;
        check();

        // 4. Same-cycle alloc and write to r4: data written, busy stays set.
        do_write(4'd4, 16'h00AA);
        do_alloc(4'd4);
        tick();
        idle();
        rd_addr1 = 4'd4;
        push(S_DATA1, "t4_r4", 32'h00AA);
        push(S_BUSY1, "t4_busy4", 32'h1);
        push(S_CNT,   "t4_cnt2", 32'h2);
        #1;
        check();

        // WAW on r7 with a same-cycle write: count unchanged.
        do_write(4'd7, 16'h7777);
        do_alloc(4'd7);
        tick();
        idle();
        read_check(4'd7, 4'd4, "t4_waw");
        // Alloc r0 is a no-op.
        do_alloc(4'd0);
        tick();
        idle();
        read_check(4'd0, 4'd7, "t4_alloc_r0");
        // Different addresses in one cycle: r10 allocated first, then write r10 + alloc r11.
        do_alloc(4'd10);
        tick();
        idle();
        do_write(4'd10, 16'hA0A0);
        do_alloc(4'd11);
        read_check(4'd10, 4'd11, "t4_split_pre");
        tick();
        idle();
        read_check(4'd10, 4'd11, "t4_split_post");

        // 5. Same-cycle read of r9 while writing it (r9 first set to 0001).
        do_write(4'd9, 16'h0001);
        tick();
        idle();
        do_write(4'd9, 16'h5A5A);
        rd_addr1 = 4'd9;
        rd_addr2 = 4'd9;
`ifdef RF_BYPASS_EN
        push(S_DATA1, "t5_same_cycle_p1", 32'h5A5A);
        push(S_DATA2, "t5_same_cycle_p2", 32'h5A5A);
`else
        push(S_DATA1, "t5_same_cycle_p1", 32'h0001);
        push(S_DATA2, "t5_same_cycle_p2", 32'h0001);
`endif
        #1;
        check();
        tick();
        idle();
        read_check(4'd9, 4'd0, "t5_after");
        // Same-cycle write + alloc of busy r11 read back before the edge.
        do_write(4'd11, 16'hB0B0);
        do_alloc(4'd11);
        read_check(4'd11, 4'd9, "t5_wr_alloc");
        tick();
        idle();
        // Same-cycle write of busy r4 without alloc.
        do_write(4'd4, 16'h4444);
        read_check(4'd4, 4'd11, "t5_wr_busy");
        tick();
        idle();
        read_check(4'd4, 4'd11, "t5_wr_busy_post");
        // Writing r0 while reading r0 is never forwarded.
        do_write(4'd0, 16'hFFFF);
        read_check(4'd0, 4'd0, "t5_r0_nobypass");
        tick();
        idle();

        // 6. Reset dominates a same-cycle alloc and write; r5 (BEEF) clears.
        rd_addr1 = 4'd5;
        push(S_DATA1, "t6_r5_before", 32'hBEEF);
        #1;
        check();
        rst = 1'b1;
        do_alloc(4'd2);
        do_write(4'd6, 16'hFFFF);
        tick();
        rst = 1'b0;
        idle();
        rd_addr1 = 4'd2;
        rd_addr2 = 4'd5;
        push(S_BUSY1, "t6_busy2", 32'h0);
        push(S_CNT,   "t6_cnt0",  32'h0);
        push(S_DATA2, "t6_r5_cleared", 32'h0);
        #1;
        check();
        for (int a = 0; a < NREGS; a++) read_check(4'(a), 4'(NREGS - 1 - a), "t6_sweep");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
